// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// State encodings, instruction width and the little-endian byte packer.
package ifetch_ctrl_pkg;

   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      S_LOOK = 2'd0,
      S_MEM  = 2'd1,
      S_FILL = 2'd2
   } fetch_state_e;

   // Byte 0 is the lowest address and lands in bits 7:0.
   function automatic logic [INST_W-1:0] pack_le(input logic [3:0][7:0] b);
      return {b[3], b[2], b[1], b[0]};
   endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// icache lookup/fill and byte-memory request bundle seen by the fetch controller.
// master = fetch controller, slave = icache plus memory controller side.
interface ifetch_ctrl_if #(
   parameter int ADDR_W = 32
);
   import ifetch_ctrl_pkg::*;

   logic [ADDR_W-1:0] ic_raddr_o;
   logic              ic_hit_i;
   logic [INST_W-1:0] ic_inst_i;
   logic              ic_we_o;
   logic [ADDR_W-1:0] ic_waddr_o;
   logic [INST_W-1:0] ic_winst_o;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_valid_i;
   logic [7:0]        mem_byte_i;

   modport master (
      output ic_raddr_o, ic_we_o, ic_waddr_o, ic_winst_o, mem_req_o, mem_addr_o,
      input  ic_hit_i, ic_inst_i, mem_valid_i, mem_byte_i
   );

   modport slave (
      input  ic_raddr_o, ic_we_o, ic_waddr_o, ic_winst_o, mem_req_o, mem_addr_o,
      output ic_hit_i, ic_inst_i, mem_valid_i, mem_byte_i
   );

endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: icache lookup, byte-wise miss refill, IF/ID register.
// Define IFETCH_PERF_EN to add the hit_cnt_o / miss_cnt_o performance counters.
//
// state  | meaning
// S_LOOK | pc presented to icache; hit -> IF/ID, miss -> S_MEM
// S_MEM  | collecting 4 bytes at pc+cnt from the memory controller
// S_FILL | one-cycle icache write of the assembled word, then re-lookup
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              stall_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   ifetch_ctrl_if.master     bus,
   output logic              if_valid_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   fetch_state_e      state_q, state_n;
   logic [ADDR_W-1:0] pc_q, pc_n;
   logic [1:0]        cnt_q, cnt_n;
   logic [3:0][7:0]   byte_q, byte_n;
   logic              if_valid_n;
   logic [ADDR_W-1:0] if_pc_n;
   logic [INST_W-1:0] if_inst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOOK;
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
         byte_q     <= '0;
         if_valid_o <= 1'b0;
         if_pc_o    <= '0;
         if_inst_o  <= ZERO_WORD;
      end else if (rdy) begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         cnt_q      <= cnt_n;
         byte_q     <= byte_n;
         if_valid_o <= if_valid_n;
         if_pc_o    <= if_pc_n;
         if_inst_o  <= if_inst_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      cnt_n      = cnt_q;
      byte_n     = byte_q;
      if_valid_n = if_valid_o;
      if_pc_n    = if_pc_o;
      if_inst_n  = if_inst_o;

      if (jump_i) begin
         pc_n       = jump_addr_i;
         cnt_n      = '0;
         if_valid_n = 1'b0;
         state_n    = S_LOOK;
      end else begin
         // Unstalled cycles without a hit present a bubble so no pc is delivered twice.
         if (!stall_i) if_valid_n = 1'b0;
         case (state_q)
            S_LOOK: begin
               if (bus.ic_hit_i) begin
                  if (!stall_i) begin
                     if_valid_n = 1'b1;
                     if_pc_n    = pc_q;
                     if_inst_n  = bus.ic_inst_i;
                     pc_n       = pc_q + ADDR_W'(4);
                  end
               end else begin
                  cnt_n   = '0;
                  state_n = S_MEM;
               end
            end
            S_MEM: begin
               if (bus.mem_valid_i) begin
                  byte_n[cnt_q] = bus.mem_byte_i;
                  cnt_n         = cnt_q + 2'd1;
                  if (cnt_q == 2'd3) state_n = S_FILL;
               end
            end
            S_FILL:  state_n = S_LOOK;
            default: state_n = S_LOOK;
         endcase
      end
   end

   assign bus.ic_raddr_o = pc_q;
   assign bus.mem_req_o  = (state_q == S_MEM);
   assign bus.mem_addr_o = pc_q + ADDR_W'(cnt_q);
   assign bus.ic_we_o    = (state_q == S_FILL);
   assign bus.ic_waddr_o = pc_q;
   assign bus.ic_winst_o = pack_le(byte_q);

`ifdef IFETCH_PERF_EN
   logic hit_inc, miss_inc;

   assign hit_inc  = rdy && !jump_i && (state_q == S_LOOK) && bus.ic_hit_i && !stall_i;
   assign miss_inc = rdy && !jump_i && (state_q == S_LOOK) && !bus.ic_hit_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (hit_inc)  hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (miss_inc) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule
